// File: rtl/bht_2lvl_predictor_pkg.sv
// Shared definitions for the two-level local-history branch predictor.
// Holds the per-entry storage layout, the saturating-counter constants and
// helpers that derive the fetch geometry from the compressed-ISA setting.
// The entry struct is sized for the longest supported history (4 bits);
// the predictor masks history to its configured length, so counters that a
// shorter history can never select keep their reset value and are constant.
package bht_2lvl_predictor_pkg;

  localparam int unsigned BHT_HIST_MAX = 4;

  localparam logic [1:0] SAT_CTR_RST = 2'b01;
  localparam logic [1:0] SAT_CTR_MAX = 2'b11;
  localparam logic [1:0] SAT_CTR_MIN = 2'b00;

  typedef struct packed {
    logic                                valid;
    logic [BHT_HIST_MAX-1:0]             hist;
    logic [2**BHT_HIST_MAX-1:0][1:0]     ctr;
  } bht_entry_t;

  localparam bht_entry_t BHT_ENTRY_RST = '{
    valid: 1'b0,
    hist:  '0,
    ctr:   {(2**BHT_HIST_MAX){SAT_CTR_RST}}
  };

  // With compressed instructions a fetch block carries two 16-bit slots.
  function automatic int unsigned instr_per_fetch(input bit rvc);
    return rvc ? 2 : 1;
  endfunction

  // Lowest PC bit that distinguishes instruction slots.
  function automatic int unsigned pc_offset(input bit rvc);
    return rvc ? 1 : 2;
  endfunction

endpackage

// File: rtl/bht_2lvl_predictor_sat_ctr2.sv
// Combinational 2-bit saturating counter step.
// Ports:
//   ctr     current counter value
//   taken   resolved direction (1 = increment, 0 = decrement)
//   ctr_nxt counter value after the step, clamped to 00..11
module bht_sat_ctr2
  import bht_2lvl_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != SAT_CTR_MAX) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != SAT_CTR_MIN) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/bht_2lvl_predictor.sv
// Two-level local-history branch history table.
// Each entry keeps a local history register that selects one of
// 2^BHT_HIST 2-bit saturating counters; the selected counter's MSB is the
// predicted direction. Storage is a flop array of NR_ROWS x INSTR_PER_FETCH.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_bp_i               clear every entry (wins over a same-cycle update)
//   debug_mode_i             suppress updates while in debug mode
//   vpc_i                    fetch-block PC, read combinationally
//   bht_update_valid_i       resolved conditional branch strobe
//   bht_update_pc_i          PC of the resolved branch
//   bht_update_taken_i       resolved direction
//   bht_pred_valid_o         per-slot entry valid
//   bht_pred_taken_o         per-slot predicted taken
module bht_2lvl_predictor
  import bht_2lvl_predictor_pkg::*;
#(
  parameter int unsigned VLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 128,
  parameter int unsigned BHT_HIST    = 3,
  parameter bit          RVC         = 1'b1,
  localparam int unsigned INSTR_PER_FETCH = instr_per_fetch(RVC)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic                       bht_update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_taken_o
);

  localparam int unsigned OFFSET        = pc_offset(RVC);
  localparam int unsigned NR_ROWS       = BHT_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned INDEX_BITS    = $clog2(NR_ROWS);
  localparam int unsigned SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam logic [BHT_HIST_MAX-1:0] HIST_MASK = BHT_HIST_MAX'((2**BHT_HIST) - 1);

  bht_entry_t bht_q [NR_ROWS][INSTR_PER_FETCH];

  logic [INDEX_BITS-1:0]   pred_row;
  logic [INDEX_BITS-1:0]   upd_row;
  logic [SLOT_W-1:0]       upd_slot;
  bht_entry_t              upd_entry;
  logic [BHT_HIST_MAX-1:0] upd_hist;
  logic [BHT_HIST_MAX-1:0] upd_hist_nxt;
  logic [1:0]              upd_ctr;
  logic [1:0]              upd_ctr_nxt;
  logic                    upd_en;
  logic                    unused_bits;

  assign pred_row = vpc_i[OFFSET+ROW_ADDR_BITS +: INDEX_BITS];
  assign upd_row  = bht_update_pc_i[OFFSET+ROW_ADDR_BITS +: INDEX_BITS];

  // Without compressed instructions a row holds a single slot.
  generate
    if (ROW_ADDR_BITS > 0) begin : g_slot
      assign upd_slot = bht_update_pc_i[OFFSET +: SLOT_W];
    end else begin : g_no_slot
      assign upd_slot = '0;
    end
  endgenerate

  // No tag: remaining PC bits are deliberately ignored, so aliasing occurs.
  assign unused_bits = ^{vpc_i, bht_update_pc_i, upd_entry};

  // ---- prediction: pure read of current state, no update bypass ----
  always_comb begin
    bht_pred_valid_o = '0;
    bht_pred_taken_o = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      bht_pred_valid_o[i] = bht_q[pred_row][i].valid;
      bht_pred_taken_o[i] = bht_q[pred_row][i].ctr[bht_q[pred_row][i].hist][1];
    end
  end

  // ---- update path: counter and history both use the old history ----
  assign upd_en       = bht_update_valid_i && !debug_mode_i && !flush_bp_i;
  assign upd_entry    = bht_q[upd_row][upd_slot];
  assign upd_hist     = upd_entry.hist & HIST_MASK;
  assign upd_ctr      = upd_entry.ctr[upd_hist];
  assign upd_hist_nxt = {upd_hist[BHT_HIST_MAX-2:0], bht_update_taken_i} & HIST_MASK;

  bht_sat_ctr2 u_sat_ctr (
    .ctr     (upd_ctr),
    .taken   (bht_update_taken_i),
    .ctr_nxt (upd_ctr_nxt)
  );

  // ---- state commit ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_ROWS; r++)
        for (int s = 0; s < INSTR_PER_FETCH; s++)
          bht_q[r][s] <= BHT_ENTRY_RST;
    end else if (flush_bp_i) begin
      for (int r = 0; r < NR_ROWS; r++)
        for (int s = 0; s < INSTR_PER_FETCH; s++)
          bht_q[r][s] <= BHT_ENTRY_RST;
    end else if (upd_en) begin
      bht_q[upd_row][upd_slot].valid          <= 1'b1;
      bht_q[upd_row][upd_slot].hist           <= upd_hist_nxt;
      bht_q[upd_row][upd_slot].ctr[upd_hist]  <= upd_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_bht_2lvl_predictor.sv
// Bench for bht_2lvl_predictor with default parameters
// (VLEN=32, 128 entries, 3-bit history, compressed support on).
module tb_bht_2lvl_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dbg;
  logic [31:0] vpc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  pred_valid;
  logic [1:0]  pred_taken;

  int passed = 0;
  int total  = 0;

  // Reference state: one record per entry, entry number = pc[7:1].
  int m_valid [128];
  int m_hist  [128];
  int m_ctr   [128][8];

  bht_2lvl_predictor dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_bp_i         (flush),
    .debug_mode_i       (dbg),
    .vpc_i              (vpc),
    .bht_update_valid_i (upd_valid),
    .bht_update_pc_i    (upd_pc),
    .bht_update_taken_i (upd_taken),
    .bht_pred_valid_o   (pred_valid),
    .bht_pred_taken_o   (pred_taken)
  );

  always #5 clk = ~clk;

  function automatic int entry_of(input logic [31:0] pc);
    return int'((pc >> 1) % 128);
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < 128; e++) begin
      m_valid[e] = 0;
      m_hist[e]  = 0;
      for (int h = 0; h < 8; h++) m_ctr[e][h] = 1;
    end
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit t);
    int e, h;
    e = entry_of(pc);
    h = m_hist[e];
    if (t) m_ctr[e][h] = (m_ctr[e][h] < 3) ? m_ctr[e][h] + 1 : 3;
    else   m_ctr[e][h] = (m_ctr[e][h] > 0) ? m_ctr[e][h] - 1 : 0;
    m_hist[e]  = (h * 2 + (t ? 1 : 0)) % 8;
    m_valid[e] = 1;
  endfunction

  function automatic void model_predict(input logic [31:0] pc,
                                        output logic [1:0] v, output logic [1:0] t);
    int base;
    base = int'(((pc >> 2) % 64) * 2);
    for (int i = 0; i < 2; i++) begin
      v[i] = (m_valid[base+i] != 0);
      t[i] = (m_ctr[base+i][m_hist[base+i]] >= 2);
    end
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  // One clock: drive at negedge, check prediction (pre-update state),
  // then advance the model at the posedge.
  task automatic cycle(input logic [31:0] p_vpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input bit d, input bit fl);
    logic [1:0] ev, et;
    @(negedge clk);
    vpc = p_vpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; dbg = d; flush = fl;
    #1;
    model_predict(p_vpc, ev, et);
    chk("pred_valid", pred_valid, ev);
    chk("pred_taken", pred_taken, et);
    @(posedge clk);
    if (fl) model_reset();
    else if (uv && !d) model_update(upc, ut);
  endtask

  initial begin
    logic [31:0] pa, pb;
    bit          t;
    logic [4:0]  sat_up   = 5'b11000;  // bit k: taken[1] after k+1 taken updates
    logic [3:0]  sat_down = 4'b0100;   // bit k: taken[1] after k+1 not-taken updates

    rst_n = 1'b0; flush = 1'b0; dbg = 1'b0; vpc = 32'h8000_0000;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_valid", pred_valid, 2'b00);
    chk("in_reset_taken", pred_taken, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state visible after release
    cycle(32'h8000_0000, 0, '0, 0, 0, 0);
    #1;
    chk("reset_valid", pred_valid, 2'b00);
    chk("reset_taken", pred_taken, 2'b00);

    // Pattern learning: T,T,N repeated at 0x8000_0010 (slot 0)
    for (int k = 0; k < 12; k++)
      cycle(32'h8000_0010, 1, 32'h8000_0010, (k % 3) != 2, 0, 0);
    for (int k = 12; k < 15; k++) begin
      #1;
      chk("pattern_valid", {1'b0, pred_valid[0]}, 2'b01);
      chk("pattern_phase", {1'b0, pred_taken[0]}, {1'b0, (k % 3) != 2});
      cycle(32'h8000_0010, 1, 32'h8000_0010, (k % 3) != 2, 0, 0);
    end

    // Saturation at 0x8000_0042 (row 0x10, slot 1)
    for (int k = 0; k < 5; k++) begin
      cycle(32'h8000_0042, 1, 32'h8000_0042, 1, 0, 0);
      #1;
      chk("sat_up", {1'b0, pred_taken[1]}, {1'b0, sat_up[k]});
    end
    for (int k = 0; k < 4; k++) begin
      cycle(32'h8000_0042, 1, 32'h8000_0042, 0, 0, 0);
      #1;
      chk("sat_down", {1'b0, pred_taken[1]}, {1'b0, sat_down[k]});
    end

    // Same-cycle collision: the in-task check sees old state, next cycle new
    cycle(32'h8000_0010, 1, 32'h8000_0010, 1, 0, 0);
    cycle(32'h8000_0010, 1, 32'h8000_0010, 1, 0, 0);
    cycle(32'h8000_0010, 0, '0, 0, 0, 0);

    // Debug mode: updates ignored, predictions still produced
    for (int k = 0; k < 4; k++)
      cycle(32'h8000_0010, 1, 32'h8000_0010, k[0], 1, 0);
    cycle(32'h8000_0042, 1, 32'h8000_0044, 1, 1, 0);
    cycle(32'h8000_0044, 0, '0, 0, 0, 0);
    #1;
    chk("debug_no_write", pred_valid, 2'b00);

    // Flush priority over a same-cycle update
    for (int r = 0; r < 4; r++)
      cycle(32'h8000_0000, 1, 32'h8000_0100 + 32'(r * 4), 1, 0, 0);
    cycle(32'h8000_0100, 1, 32'h8000_0102, 1, 0, 1);
    for (int r = 0; r < 4; r++) begin
      cycle(32'h8000_0100 + 32'(r * 4), 0, '0, 0, 0, 0);
      #1;
      chk("flush_row", pred_valid, 2'b00);
    end

    // Randomised traffic concentrated on a few entries
    for (int k = 0; k < 400; k++) begin
      pa = $urandom;
      pa[7:1] = 7'($urandom_range(0, 15));
      pb = $urandom;
      if ($urandom_range(0, 1) == 0) pb = pa;
      else pb[7:1] = 7'($urandom_range(0, 15));
      t = bit'($urandom_range(0, 1));
      cycle(pb, $urandom_range(0, 3) != 0, pa, t,
            $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset between edges
    cycle(32'h8000_0010, 1, 32'h8000_0010, 1, 0, 0);
    @(negedge clk);
    vpc = 32'h8000_0010; upd_valid = 1'b0; dbg = 1'b0; flush = 1'b0;
    #1;
    chk("pre_async_valid", {1'b0, pred_valid[0]}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", pred_valid, 2'b00);
    chk("async_rst_taken", pred_taken, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++)
      cycle(32'h8000_0010, 1, 32'h8000_0010, k != 2, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
